// File: rtl/ram_cache_dm.sv
// ram_cache_dm -- direct-mapped, write-through, no-write-allocate data cache.
//
// Sits between the CPU data port and a synchronous data RAM. Read hits are
// answered combinationally in the same cycle. A read miss stalls the CPU while
// the whole line is burst-read from RAM. Writes always go straight to RAM, and
// they update the cached copy only when the line is already present.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cpu_in_m          read data to CPU (don't-care while cpu_stall is high)
//   cpu_out_m         write data from CPU
//   cpu_write_m       CPU write request
//   cpu_read_m        CPU read request
//   cpu_data_addr     CPU word address
//   cpu_stall         CPU must hold its request inputs while high
//   cache_flush       one-cycle pulse, invalidates every line
//   ram_in_m          RAM read data, RAM_READ_LATENCY cycles after ram_read_m
//   ram_out_m         RAM write data
//   ram_write_m       RAM write strobe
//   ram_read_m        RAM read strobe (refill only)
//   ram_data_addr     RAM word address
//   hit_count         saturating count of read hits
//   miss_count        saturating count of read misses
module ram_cache_dm #(
   parameter int unsigned DATA_WIDTH         = 16,
   parameter int unsigned RAM_REGISTER_COUNT = 1024,
   parameter int unsigned CACHE_LINES        = 16,
   parameter int unsigned LINE_WORDS         = 4,
   parameter int unsigned RAM_READ_LATENCY   = 1,
   localparam int unsigned ADDR_W            = $clog2(RAM_REGISTER_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] cpu_in_m,
   input  logic [DATA_WIDTH-1:0] cpu_out_m,
   input  logic                  cpu_write_m,
   input  logic                  cpu_read_m,
   input  logic [ADDR_W-1:0]     cpu_data_addr,
   output logic                  cpu_stall,
   input  logic                  cache_flush,
   input  logic [DATA_WIDTH-1:0] ram_in_m,
   output logic [DATA_WIDTH-1:0] ram_out_m,
   output logic                  ram_write_m,
   output logic                  ram_read_m,
   output logic [ADDR_W-1:0]     ram_data_addr,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
);

   localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W   = $clog2(CACHE_LINES);
   localparam int unsigned TAG_LSB = OFF_W + IDX_W;
   // A cache as large as the RAM has no tag bits; keep a 1-bit constant-zero tag.
   localparam int unsigned TAG_W   = (ADDR_W > TAG_LSB) ? (ADDR_W - TAG_LSB) : 1;
   localparam int unsigned R       = RAM_READ_LATENCY;
   localparam int unsigned NWORDS  = CACHE_LINES * LINE_WORDS;

   typedef enum logic [0:0] {StIdle, StFill} state_e;

   state_e state_q, state_d;

   // Line storage
   logic [CACHE_LINES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
   logic [DATA_WIDTH-1:0]  data_q [NWORDS];

   // Refill bookkeeping
   logic [ADDR_W-1:0]      fill_base_q;
   logic [OFF_W:0]         issue_cnt_q;   // MSB set once all words have been requested
   logic [R-1:0]           pipe_vld_q;
   logic [OFF_W-1:0]       pipe_off_q [R];
   logic                   pend_flush_q;
   logic                   just_filled_q;

   // Address split
   logic [OFF_W-1:0]       cpu_off;
   logic [IDX_W-1:0]       cpu_idx;
   logic [TAG_W-1:0]       cpu_tag;
   logic [IDX_W-1:0]       fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic [ADDR_W-1:0]      fill_addr;

   logic hit;
   logic read_miss;
   logic hit_counted;
   logic issuing;
   logic capture;
   logic fill_last;
   logic flush_now;
   logic write_hit;

   assign cpu_off   = cpu_data_addr[OFF_W-1:0];
   assign cpu_idx   = cpu_data_addr[OFF_W +: IDX_W];
   assign cpu_tag   = TAG_W'(cpu_data_addr >> TAG_LSB);
   assign fill_idx  = fill_base_q[OFF_W +: IDX_W];
   assign fill_tag  = TAG_W'(fill_base_q >> TAG_LSB);
   assign fill_addr = fill_base_q | ADDR_W'(issue_cnt_q[OFF_W-1:0]);

   assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign cpu_in_m  = data_q[{cpu_idx, cpu_off}];
   assign ram_out_m = cpu_out_m;

   assign read_miss   = (state_q == StIdle) && cpu_read_m && !hit;
   // The cycle right after a refill completes the stalled read; it was
   // already counted as a miss.
   assign hit_counted = (state_q == StIdle) && cpu_read_m && hit && !just_filled_q;
   assign issuing     = (state_q == StFill) && !issue_cnt_q[OFF_W];
   assign capture     = (state_q == StFill) && pipe_vld_q[R-1];
   assign fill_last   = capture && (pipe_off_q[R-1] == OFF_W'(LINE_WORDS - 1));
   assign flush_now   = pend_flush_q || cache_flush;
   assign write_hit   = ram_write_m && hit;

   // ------------------------------------------------------------------------
   // FSM next state and bus outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cpu_stall     = 1'b1;
      ram_read_m    = 1'b0;
      ram_write_m   = 1'b0;
      ram_data_addr = cpu_data_addr;
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               cpu_stall   = cpu_read_m && !hit;
               ram_write_m = cpu_write_m && !(cpu_read_m && !hit);
               if (cpu_read_m && !hit) begin
                  state_d = StFill;
               end
            end
            StFill: begin
               cpu_stall  = 1'b1;
               ram_read_m = issuing;
               if (issuing) begin
                  ram_data_addr = fill_addr;
               end
               if (fill_last) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Control state: valid bits, refill sequencing, flush, counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q       <= '0;
         fill_base_q   <= '0;
         issue_cnt_q   <= '0;
         pipe_vld_q    <= '0;
         for (int unsigned k = 0; k < R; k++) begin
            pipe_off_q[k] <= '0;
         end
         pend_flush_q  <= 1'b0;
         just_filled_q <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         just_filled_q <= fill_last;

         // Latency pipe: tracks which word offset RAM will return each cycle.
         pipe_vld_q[0] <= issuing;
         pipe_off_q[0] <= issue_cnt_q[OFF_W-1:0];
         for (int unsigned k = 1; k < R; k++) begin
            pipe_vld_q[k] <= pipe_vld_q[k-1];
            pipe_off_q[k] <= pipe_off_q[k-1];
         end

         if (issuing) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
         end

         if (hit_counted && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
         end

         unique case (state_q)
            StIdle: begin
               if (read_miss) begin
                  fill_base_q <= {cpu_data_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  issue_cnt_q <= '0;
                  if (miss_count != 16'hFFFF) begin
                     miss_count <= miss_count + 16'd1;
                  end
               end
               if (cache_flush) begin
                  valid_q <= '0;
               end else if (read_miss) begin
                  // Old contents of this slot are about to be overwritten.
                  valid_q[cpu_idx] <= 1'b0;
               end
            end
            StFill: begin
               if (cache_flush) begin
                  pend_flush_q <= 1'b1;
               end
               if (fill_last) begin
                  pend_flush_q <= 1'b0;
                  if (flush_now) begin
                     valid_q <= '0;
                  end else begin
                     valid_q[fill_idx] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Tag and data arrays (no reset; qualified by the valid bits)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (capture) begin
         data_q[{fill_idx, pipe_off_q[R-1]}] <= ram_in_m;
      end
      if (write_hit) begin
         data_q[{cpu_idx, cpu_off}] <= cpu_out_m;
      end
      if (fill_last && !flush_now) begin
         tag_q[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_ram_cache_dm.sv
module tb_ram_cache_dm;

   localparam int LW   = 4;
   localparam int RLAT = 1;
   localparam int MISS_STALL = LW + RLAT + 1;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_in_m, cpu_out_m, ram_in_m, ram_out_m, hit_count, miss_count;
   logic [9:0]  cpu_data_addr, ram_data_addr;
   logic        cpu_write_m, cpu_read_m, cpu_stall, cache_flush;
   logic        ram_write_m, ram_read_m;
   logic        load_en;

   int total = 0;
   int bad   = 0;

   ram_cache_dm dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_in_m      (cpu_in_m),
      .cpu_out_m     (cpu_out_m),
      .cpu_write_m   (cpu_write_m),
      .cpu_read_m    (cpu_read_m),
      .cpu_data_addr (cpu_data_addr),
      .cpu_stall     (cpu_stall),
      .cache_flush   (cache_flush),
      .ram_in_m      (ram_in_m),
      .ram_out_m     (ram_out_m),
      .ram_write_m   (ram_write_m),
      .ram_read_m    (ram_read_m),
      .ram_data_addr (ram_data_addr),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural RAM attached to the DUT ----------------
   logic [15:0] mem     [1024];
   logic [15:0] rd_pipe [RLAT];
   int          rd_log  [$];

   function automatic logic [15:0] init_word(input int i);
      case (i)
         'h010:   return 16'hA0A0;
         'h011:   return 16'hB1B1;
         'h012:   return 16'hC2C2;
         'h013:   return 16'hD3D3;
         default: return 16'((i * 40503 + 12345) ^ (i >> 3));
      endcase
   endfunction

   always @(posedge clk) begin
      if (ram_read_m) begin
         rd_pipe[0] <= mem[ram_data_addr];
         rd_log.push_back(int'(ram_data_addr));
      end
      for (int k = 1; k < RLAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (load_en) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else if (ram_write_m) begin
         mem[ram_data_addr] <= ram_out_m;
      end
   end
   assign ram_in_m = rd_pipe[RLAT-1];

   // ---------------- reference model (spec level) ----------------
   // Memory contents as the CPU sees them, plus which line each slot holds.
   logic [15:0] ref_mem [1024];
   bit          mv [16];
   int          mt [16];
   int          exp_hit  = 0;
   int          exp_miss = 0;
   logic [15:0] exp_q [$];

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitor: pops expected read data ----------------
   always @(negedge clk) begin
      if (!reset && cpu_read_m && !cpu_stall) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read: addr %0h with no expected entry", cpu_data_addr);
         end else begin
            check("read_data", 32'(cpu_in_m), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_counts();
      check("hit_count", 32'(hit_count), 32'(exp_hit));
      check("miss_count", 32'(miss_count), 32'(exp_miss));
   endtask

   task automatic model_invalidate();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_flush();
      cache_flush = 1'b1;
      @(posedge clk); #1;
      cache_flush = 1'b0;
      model_invalidate();
   endtask

   task automatic do_write(input int a, input logic [15:0] d);
      cpu_write_m   = 1'b1;
      cpu_data_addr = 10'(a);
      cpu_out_m     = d;
      @(negedge clk);
      check("wr_strobe", 32'(ram_write_m), 32'd1);
      check("wr_addr", 32'(ram_data_addr), 32'(a));
      check("wr_data", 32'(ram_out_m), 32'(d));
      ref_mem[a] = d;
      @(posedge clk); #1;
      cpu_write_m = 1'b0;
   endtask

   // Read (optionally with a simultaneous write of wd); flush_after > 0 pulses
   // cache_flush in the stall cycle following that many stall cycles.
   task automatic do_read(input int a, input int flush_after, input bit wr,
                          input logic [15:0] wd);
      int  idx, tg, exp_stall, rmisses, n, wr_in_stall, refill_bad;
      bit  is_hit, done;
      idx = (a >> 2) % 16;
      tg  = a >> 6;
      is_hit = mv[idx] && (mt[idx] == tg);
      if (is_hit) begin
         exp_hit   = sat(exp_hit + 1);
         rmisses   = 0;
      end else begin
         rmisses   = (flush_after > 0) ? 2 : 1;
         exp_miss  = sat(exp_miss + rmisses);
         if (flush_after > 0) model_invalidate();
         mv[idx] = 1'b1;
         mt[idx] = tg;
      end
      exp_stall = rmisses * MISS_STALL;
      exp_q.push_back(ref_mem[a]);
      rd_log.delete();
      cpu_read_m    = 1'b1;
      cpu_write_m   = wr;
      cpu_out_m     = wd;
      cpu_data_addr = 10'(a);
      n = 0; done = 1'b0; wr_in_stall = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            done = 1'b1;
         end else begin
            n++;
            if (ram_write_m) wr_in_stall++;
            @(posedge clk); #1;
            cache_flush = (n == flush_after);
         end
      end
      cache_flush = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL read_timeout: addr %0h still stalled after %0d cycles", a, n);
      end
      check("stall_cycles", 32'(n), 32'(exp_stall));
      check("wr_during_stall", 32'(wr_in_stall), 32'd0);
      check("rd_wr_strobe", 32'(ram_write_m), 32'(wr));
      if (wr) ref_mem[a] = wd;
      if (!is_hit) begin
         check("refill_count", 32'(rd_log.size()), 32'(LW * rmisses));
         refill_bad = 0;
         foreach (rd_log[i]) if (rd_log[i] != ((a & ~(LW - 1)) + (i % LW))) refill_bad++;
         check("refill_addr", 32'(refill_bad), 32'd0);
      end
      @(posedge clk); #1;
      cpu_read_m  = 1'b0;
      cpu_write_m = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          r, a, n;
      logic [15:0] d;
      reset = 1'b1; load_en = 1'b1;
      cpu_read_m = 1'b1; cpu_write_m = 1'b1; cache_flush = 1'b0;
      cpu_data_addr = 10'h155; cpu_out_m = 16'h1111;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      model_invalidate();
      repeat (2) @(posedge clk);
      #1 load_en = 1'b0;
      @(negedge clk);
      check("rst_stall", 32'(cpu_stall), 32'd1);
      check("rst_ram_read", 32'(ram_read_m), 32'd0);
      check("rst_ram_write", 32'(ram_write_m), 32'd0);
      check("rst_addr", 32'(ram_data_addr), 32'h155);
      check("rst_out", 32'(ram_out_m), 32'h1111);
      check_counts();
      @(posedge clk); #1;
      cpu_read_m = 1'b0; cpu_write_m = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Cold miss, then hits in the same line
      do_read('h012, 0, 0, '0);
      check_counts();
      do_read('h010, 0, 0, '0);
      do_read('h011, 0, 0, '0);
      do_read('h013, 0, 0, '0);
      check_counts();

      // Conflict on the same index
      do_read('h052, 0, 0, '0);
      do_read('h012, 0, 0, '0);
      check_counts();

      // Write hit, write miss (no allocate)
      do_write('h011, 16'h1234);
      do_read('h011, 0, 0, '0);
      do_write('h300, 16'h7E57);
      do_read('h300, 0, 0, '0);
      check_counts();

      // Flush in idle, flush during fill
      do_flush();
      do_read('h010, 0, 0, '0);
      do_read('h014, 2, 0, '0);
      do_read('h014, 0, 0, '0);
      check_counts();

      // Read-modify-write on a missing line, then read back the new value
      do_read('h020, 0, 1, 16'hBEEF);
      do_read('h020, 0, 0, '0);
      check_counts();

      // Randomized traffic over 4 tags x 16 indices
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         a = int'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63));
         d = 16'($urandom);
         if (r < 50)      do_read(a, 0, 0, '0);
         else if (r < 80) do_write(a, d);
         else if (r < 95) do_read(a, 0, 1, d);
         else             do_flush();
         if (i % 50 == 49) check_counts();
      end

      // Reset during the third FILL cycle
      do_flush();
      cpu_read_m = 1'b1; cpu_data_addr = 10'h012;
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (cpu_stall) n++;
         @(posedge clk); #1;
      end
      reset = 1'b1; cpu_write_m = 1'b1; cpu_out_m = 16'h5A5A;
      @(negedge clk);
      check("pre_reset_stall", 32'(n), 32'd3);
      check("midfill_rst_stall", 32'(cpu_stall), 32'd1);
      check("midfill_rst_read", 32'(ram_read_m), 32'd0);
      check("midfill_rst_write", 32'(ram_write_m), 32'd0);
      check("midfill_rst_addr", 32'(ram_data_addr), 32'h012);
      check("midfill_rst_out", 32'(ram_out_m), 32'h5A5A);
      model_invalidate();
      exp_hit = 0; exp_miss = 0;
      check_counts();
      @(posedge clk); #1;
      cpu_read_m = 1'b0; cpu_write_m = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_read('h012, 0, 0, '0);
      do_read('h012, 0, 0, '0);
      check_counts();

      // Hit counter saturation
      for (int i = 0; i < 70000; i++) exp_q.push_back(ref_mem['h013]);
      cpu_read_m = 1'b1; cpu_data_addr = 10'h013;
      repeat (70000) @(posedge clk);
      #1 cpu_read_m = 1'b0;
      exp_hit = sat(exp_hit + 70000);
      check_counts();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_cache_dm.md
# ram_cache_dm

Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the synchronous data RAM. It is the parametrised successor of the pass-through `ram_cache` and presents the same CPU-side and RAM-side port set. It adds multi-word lines, burst refill against a RAM with configurable read latency, a flush input, and hit/miss counters. Read hits return data in the same cycle; read misses stall the CPU while the line refills.

## Interface
- DATA_WIDTH, 16: word width.
- RAM_REGISTER_COUNT, 1024: RAM depth in words (power of two). ADDR_W = $clog2(RAM_REGISTER_COUNT).
- CACHE_LINES, 16: number of lines (power of two, ≥2).
- LINE_WORDS, 4: words per line (power of two, ≥2). CACHE_LINES*LINE_WORDS ≤ RAM_REGISTER_COUNT.
- RAM_READ_LATENCY, 1: cycles from `ram_read_m` to valid `ram_in_m` (1..4).
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_in_m  out  DATA_WIDTH  read data to CPU.
- cpu_out_m  in  DATA_WIDTH  write data from CPU.
- cpu_write_m  in  1  CPU write request.
- cpu_read_m  in  1  CPU read request.
- cpu_data_addr  in  ADDR_W  CPU word address.
- cpu_stall  out  1  CPU must hold all request inputs while high.
- cache_flush  in  1  single-cycle pulse; invalidate all lines.
- ram_in_m  in  DATA_WIDTH  RAM read data.
- ram_out_m  out  DATA_WIDTH  RAM write data.
- ram_write_m  out  1  RAM write strobe.
- ram_read_m  out  1  RAM read strobe (refill only).
- ram_data_addr  out  ADDR_W  RAM word address.
- hit_count  out  16  read-hit count, saturating.
- miss_count  out  16  read-miss count, saturating.

## Operation
- Address split: offset = low $clog2(LINE_WORDS) bits; index = next $clog2(CACHE_LINES) bits; tag = remaining bits.
- Storage: per line, one valid bit, one tag, and LINE_WORDS data words.
- Lookup is combinational. hit = valid[index] && tag match.
- `cpu_in_m` = the cached word at index/offset. Its value is don't-care while `cpu_stall` is high.
- FSM has two states, IDLE and FILL. Reset state is IDLE.
- IDLE:
  - `cpu_stall` = `cpu_read_m` && !hit.
  - A read miss moves the FSM to FILL and latches the line base address (tag, index, offset 0).
- FILL:
  - `cpu_stall` = 1.
  - Issue cycles: for exactly LINE_WORDS cycles, assert `ram_read_m` with `ram_data_addr` = base + issue counter (0..LINE_WORDS-1).
  - A RAM_READ_LATENCY-deep valid/offset pipe captures each returning `ram_in_m` into the line.
  - On the edge that captures the last word, set the tag and valid bit and return to IDLE. The stalled read then hits.
- Writes are write-through and no-write-allocate:
  - `ram_write_m` = `cpu_write_m` && !`cpu_stall`.
  - `ram_out_m` = `cpu_out_m`.
  - In IDLE, `ram_data_addr` = `cpu_data_addr`.
  - A write hit updates the cached word on the same edge. A write miss leaves the cache unchanged.
- Simultaneous read and write to the same address (read-modify-write): the read is serviced first, refilling if it misses. The write is issued in the non-stalled cycle and updates the cache. The read returns the pre-write value.
- Flush:
  - In IDLE, `cache_flush` clears all valid bits on the next edge.
  - In FILL, the flush is latched as pending and applied on the FILL→IDLE edge, which also invalidates the just-filled line. The stalled read therefore misses again and refills.
- Counters:
  - `miss_count` increments once per IDLE cycle that detects a read miss.
  - `hit_count` increments on each IDLE read hit, except the first cycle after a refill.
  - Writes are not counted. Both counters saturate at 16'hFFFF.

## Timing
- Read hit: zero latency; `cpu_stall` low; data valid in the same cycle.
- Read miss (L = LINE_WORDS, R = RAM_READ_LATENCY):
  - `cpu_stall` is high for L+R+1 cycles: the detect cycle plus L+R FILL cycles.
  - Data is valid in cycle L+R+1. For the defaults this is 6 stall cycles, data in cycle 6.
- Write: single cycle; `ram_write_m` is asserted in the same cycle as `cpu_write_m` when not stalled.
- While `reset` is high:
  - Forced values: `cpu_stall`=1, `ram_read_m`=0, `ram_write_m`=0, `ram_data_addr`=`cpu_data_addr`, `ram_out_m`=`cpu_out_m`.
  - State: all valid bits 0, counters 0, FSM in IDLE, pending flush 0, latency pipe cleared.
- Reset asserted mid-FILL aborts the fill. The partially filled line stays invalid.
- Refill data from an aborted fill that arrives after reset deasserts is ignored.

## Test plan
- Cold read at addr 0x012 with RAM[0x010..0x013] = A,B,C,D: stall for 6 cycles, `ram_read_m` at 0x010..0x013, then `cpu_in_m`=C. miss=1, hit=0.
- Follow-up reads at 0x010, 0x011, 0x013: no stall, returns A,B,D; hit=3.
- Conflict: read 0x052 (same index, different tag), then 0x012: both miss and refill; miss count increases by 2.
- Write 0x1234 to cached 0x011, then read it: `ram_write_m` asserted in one cycle, read hits with 0x1234. Write to uncached 0x300: RAM written, following read of 0x300 misses.
- Flush pulse in IDLE, then read 0x010: misses. Flush pulse during FILL: line invalidated at fill end, second refill occurs, total stall 12 cycles.
- Reset asserted in the 3rd FILL cycle: outputs at reset values; after release, read of the same address misses and refills cleanly. Hold 70000 hits: `hit_count` saturates at 0xFFFF.
